// File: rtl/tdm_demux_2x1_if.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_2x1_if
// Purpose  : Bundles the TDM stream input and per-channel outputs of the 2:1 demux.
//            err_clr/err_count exist only when TDM_DEMUX_ERRCNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface tdm_demux_2x1_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] ch0_out;
    logic [WIDTH-1:0] ch1_out;
    logic             ch0_stb;
    logic             ch1_stb;
    logic             locked;
    logic             sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic             err_clr;
    logic [7:0]       err_count;
`endif

    // Stream source / channel consumer side
    modport master (
        output din,
        output din_valid,
        output frame_sync,
`ifdef TDM_DEMUX_ERRCNT_EN
        output err_clr,
        input  err_count,
`endif
        input  ch0_out,
        input  ch1_out,
        input  ch0_stb,
        input  ch1_stb,
        input  locked,
        input  sync_err
    );

    // Demux side
    modport slave (
        input  din,
        input  din_valid,
        input  frame_sync,
`ifdef TDM_DEMUX_ERRCNT_EN
        input  err_clr,
        output err_count,
`endif
        output ch0_out,
        output ch1_out,
        output ch0_stb,
        output ch1_stb,
        output locked,
        output sync_err
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux_2x1.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_2x1
// Purpose  : Splits a two-slot TDM stream (slot 0 marked by frame_sync) back into
//            two registered channel outputs; tracks alignment, flags sync errors.
//            Optional saturating error counter: define TDM_DEMUX_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_2x1 #(
    parameter int WIDTH = 8
) (
    input  wire               clk,
    input  wire               reset,
    tdm_demux_2x1_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_EXP0 = 2'd1,
        ST_EXP1 = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_ch0;
    logic [WIDTH-1:0] r_ch1;
    logic             r_ch0_stb;
    logic             r_ch1_stb;
    logic             r_locked;
    logic             r_sync_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_HUNT;
            r_ch0      <= '0;
            r_ch1      <= '0;
            r_ch0_stb  <= 1'b0;
            r_ch1_stb  <= 1'b0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_ch0_stb  <= 1'b0;
            r_ch1_stb  <= 1'b0;
            r_sync_err <= 1'b0;
            if (bus.din_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (bus.frame_sync) begin
                            r_ch0     <= bus.din;
                            r_ch0_stb <= 1'b1;
                            r_locked  <= 1'b1;
                            r_state   <= ST_EXP1;
                        end
                    end
                    ST_EXP1: begin
                        if (bus.frame_sync) begin
                            // Early sync: restart the frame on this beat, stay aligned
                            r_sync_err <= 1'b1;
                            r_ch0      <= bus.din;
                            r_ch0_stb  <= 1'b1;
                        end else begin
                            r_ch1     <= bus.din;
                            r_ch1_stb <= 1'b1;
                            r_state   <= ST_EXP0;
                        end
                    end
                    ST_EXP0: begin
                        if (bus.frame_sync) begin
                            r_ch0     <= bus.din;
                            r_ch0_stb <= 1'b1;
                            r_state   <= ST_EXP1;
                        end else begin
                            r_sync_err <= 1'b1;
                            r_locked   <= 1'b0;
                            r_state    <= ST_HUNT;
                        end
                    end
                    default: begin
                        r_locked <= 1'b0;
                        r_state  <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign bus.ch0_out  = r_ch0;
    assign bus.ch1_out  = r_ch1;
    assign bus.ch0_stb  = r_ch0_stb;
    assign bus.ch1_stb  = r_ch1_stb;
    assign bus.locked   = r_locked;
    assign bus.sync_err = r_sync_err;

`ifdef TDM_DEMUX_ERRCNT_EN
    // Error event decoded from the current beat so the count moves with the pulse
    logic       w_err_event;
    logic [7:0] r_err_count;

    assign w_err_event = bus.din_valid &&
                         (((r_state == ST_EXP1) &&  bus.frame_sync) ||
                          ((r_state == ST_EXP0) && !bus.frame_sync));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (bus.err_clr) begin
            r_err_count <= 8'd0;
        end else if (w_err_event && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_2x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_2x1
// Purpose  : Self-checking bench for tdm_demux_2x1: vector table, corner
//            sequences, and randomized stream against a slot-tracking model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_2x1;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    tdm_demux_2x1_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux_2x1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       fs;
        logic [7:0] d;
        logic [7:0] e_ch0;
        logic [7:0] e_ch1;
        logic       e_stb0;
        logic       e_stb1;
        logic       e_lock;
        logic       e_err;
    } vec_t;

    vec_t vecs[16];

    // Reference model state: next expected slot, -1 while unaligned
    int         m_slot;
    logic [7:0] m_ch0, m_ch1;
    logic       m_stb0, m_stb1, m_lock, m_err;
    int         m_errcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                           input logic s0, input logic s1, input logic lk, input logic er);
        chk({tag, ".ch0_out"},  32'(bus.ch0_out),  32'(c0));
        chk({tag, ".ch1_out"},  32'(bus.ch1_out),  32'(c1));
        chk({tag, ".ch0_stb"},  32'(bus.ch0_stb),  32'(s0));
        chk({tag, ".ch1_stb"},  32'(bus.ch1_stb),  32'(s1));
        chk({tag, ".locked"},   32'(bus.locked),   32'(lk));
        chk({tag, ".sync_err"}, 32'(bus.sync_err), 32'(er));
    endtask

    // Drive one cycle of input, sample 1 time unit after the rising edge
    task automatic cycle(input logic v, input logic fs, input logic [7:0] d);
        @(negedge clk);
        bus.din_valid  = v;
        bus.frame_sync = fs;
        bus.din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_slot = -1; m_ch0 = 0; m_ch1 = 0;
        m_stb0 = 0; m_stb1 = 0; m_lock = 0; m_err = 0; m_errcnt = 0;
    endtask

    task automatic model_step(input logic v, input logic fs, input logic [7:0] d, input logic clr);
        m_stb0 = 0; m_stb1 = 0; m_err = 0;
        if (v) begin
            if (fs) begin
                // A sync beat is always slot 0; it is an error only if slot 1 was due
                if (m_slot == 1) m_err = 1;
                m_ch0 = d; m_stb0 = 1; m_lock = 1; m_slot = 1;
            end else if (m_slot == 1) begin
                m_ch1 = d; m_stb1 = 1; m_slot = 0;
            end else if (m_slot == 0) begin
                m_err = 1; m_lock = 0; m_slot = -1;
            end
        end
        if (clr) m_errcnt = 0;
        else if (m_err) m_errcnt = (m_errcnt >= 255) ? 255 : m_errcnt + 1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
`ifdef TDM_DEMUX_ERRCNT_EN
        bus.err_clr    = 1'b0;
`endif
        reset = 1'b1;

        // Reset held, then released with no beats
        repeat (3) @(posedge clk);
        #1;
        chk_all("rst_held", 8'h00, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 1, 8'hFF);
        cycle(0, 0, 8'h00);
        chk_all("rst_idle", 8'h00, 8'h00, 0, 0, 0, 0);

        // Vector table: {v, fs, din, ch0, ch1, stb0, stb1, locked, err}
        vecs[0]  = '{1, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 8'h11, 8'h11, 8'h00, 1, 0, 1, 0};
        vecs[2]  = '{1, 0, 8'h22, 8'h11, 8'h22, 0, 1, 1, 0};
        vecs[3]  = '{0, 1, 8'h99, 8'h11, 8'h22, 0, 0, 1, 0};
        vecs[4]  = '{1, 1, 8'h01, 8'h01, 8'h22, 1, 0, 1, 0};
        vecs[5]  = '{1, 0, 8'h02, 8'h01, 8'h02, 0, 1, 1, 0};
        vecs[6]  = '{1, 1, 8'h03, 8'h03, 8'h02, 1, 0, 1, 0};
        vecs[7]  = '{1, 0, 8'h04, 8'h03, 8'h04, 0, 1, 1, 0};
        vecs[8]  = '{1, 1, 8'h77, 8'h77, 8'h04, 1, 0, 1, 0};
        vecs[9]  = '{1, 1, 8'h55, 8'h55, 8'h04, 1, 0, 1, 1};
        vecs[10] = '{1, 0, 8'h33, 8'h55, 8'h33, 0, 1, 1, 0};
        vecs[11] = '{1, 0, 8'h66, 8'h55, 8'h33, 0, 0, 0, 1};
        vecs[12] = '{1, 0, 8'h44, 8'h55, 8'h33, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 8'h12, 8'h55, 8'h33, 0, 0, 0, 0};
        vecs[14] = '{1, 1, 8'h88, 8'h88, 8'h33, 1, 0, 1, 0};
        vecs[15] = '{1, 0, 8'h99, 8'h88, 8'h99, 0, 1, 1, 0};

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].v, vecs[i].fs, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].e_ch0, vecs[i].e_ch1,
                    vecs[i].e_stb0, vecs[i].e_stb1, vecs[i].e_lock, vecs[i].e_err);
        end

        // Asynchronous reset mid-frame, checked between clock edges
        cycle(1, 1, 8'h11);
        chk_all("pre_async", 8'h11, 8'h99, 1, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 8'h00, 0, 0, 0, 0);
`ifdef TDM_DEMUX_ERRCNT_EN
        chk("async_rst.err_count", 32'(bus.err_count), 32'd0);
`endif
        bus.din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Randomized stream against the reference model
        model_reset();
        for (int i = 0; i < 400; i++) begin
            logic       v, fs;
            logic [7:0] d;
            v  = ($urandom_range(0, 9) < 8);
            fs = ($urandom_range(0, 9) < 4);
            d  = 8'($urandom);
            cycle(v, fs, d);
            model_step(v, fs, d, 1'b0);
            chk_all($sformatf("rnd%0d", i), m_ch0, m_ch1, m_stb0, m_stb1, m_lock, m_err);
`ifdef TDM_DEMUX_ERRCNT_EN
            chk($sformatf("rnd%0d.err_count", i), 32'(bus.err_count), 32'(m_errcnt));
`endif
            if (bus.ch0_stb && bus.ch1_stb) chk("rnd.stb_exclusive", 32'd1, 32'd0);
        end

`ifdef TDM_DEMUX_ERRCNT_EN
        // Saturation: lock, then repeated early-sync beats each raise an error
        @(negedge clk);
        bus.err_clr = 1'b1;
        cycle(1, 1, 8'h01);
        bus.err_clr = 1'b0;
        chk("errcnt.cleared", 32'(bus.err_count), 32'd0);
        for (int i = 0; i < 260; i++) cycle(1, 1, 8'(i));
        chk("errcnt.saturated", 32'(bus.err_count), 32'd255);
        chk("errcnt.locked", 32'(bus.locked), 32'd1);
        // Clear wins over a simultaneous error
        @(negedge clk);
        bus.err_clr = 1'b1;
        cycle(1, 1, 8'h5A);
        bus.err_clr = 1'b0;
        chk("errcnt.clr_err.sync_err", 32'(bus.sync_err), 32'd1);
        chk("errcnt.clr_priority", 32'(bus.err_count), 32'd0);
        cycle(1, 1, 8'h5B);
        chk("errcnt.after_clr", 32'(bus.err_count), 32'd1);
`endif

        cycle(0, 0, 8'h00);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
